// File: rtl/usr_pkg.sv
// Shared mode encodings and sequencer state type for the shift-register controller.
package usr_pkg;
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic {IDLE, SHIFT} seq_state_t;
endpackage

// File: rtl/usr_word_fifo.sv
// Synchronous show-ahead word FIFO; the head entry is readable whenever empty is low.
module usr_word_fifo #(
  parameter int DW    = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DW-1:0]              wr_data,
  input  logic                       pop,
  output logic [DW-1:0]              rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push_ok, pop_ok;

  // Full blocks a push even when a pop happens in the same cycle (no bypass).
  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;
endmodule

// File: rtl/usr_shift_sequencer.sv
// Feeds a universal shift register: one LOAD per buffered word followed by WIDTH-1 shifts,
// and flags each fresh exit bit in step with the register's DataOut.
module usr_shift_sequencer
  import usr_pkg::*;
#(
  parameter int   WIDTH      = 4,
  parameter int   FIFO_DEPTH = 4,
  parameter logic FILL       = 1'b0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_dir,
  input  logic                          stall,
  output logic [1:0]                    usr_mode,
  output logic [WIDTH-1:0]              usr_data_in,
  output logic                          ser_valid,
  output logic                          ser_last,
  output logic                          ser_sel,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);

  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [WIDTH:0]   fifo_head;

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_last_q, ser_last_d;
  logic             ser_sel_q, ser_sel_d;
  logic [1:0]       mode_d;
  logic [WIDTH-1:0] data_d;
  logic             load_slot;

  assign in_ready  = !fifo_full && !reset;
  assign fifo_push = in_valid && in_ready;

  usr_word_fifo #(
    .DW    (WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data ({in_dir, in_data}),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign load_slot = (state_q == IDLE) || (cnt_q == CNT_LAST);

  // Issue decode looks only at stall, the registered empty flag and local state.
  always_comb begin
    mode_d      = MODE_HOLD;
    data_d      = '0;
    fifo_pop    = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    ser_valid_d = 1'b0;
    ser_last_d  = 1'b0;
    if (!reset) begin
      if (load_slot && !fifo_empty && !stall) begin
        mode_d      = MODE_LOAD;
        data_d      = fifo_head[WIDTH-1:0];
        fifo_pop    = 1'b1;
        dir_d       = fifo_head[WIDTH];
        cnt_d       = '0;
        state_d     = SHIFT;
        ser_valid_d = 1'b1;
      end else if (load_slot) begin
        if (state_q == SHIFT && !stall) state_d = IDLE;
      end else if (!stall) begin
        mode_d      = dir_q ? MODE_SHL : MODE_SHR;
        data_d      = {{(WIDTH-1){1'b0}}, FILL};
        cnt_d       = cnt_q + CNT_W'(1);
        ser_valid_d = 1'b1;
        ser_last_d  = (cnt_q == CNT_PEN);
      end
    end
    ser_sel_d = dir_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      ser_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
      ser_sel_q   <= ser_sel_d;
    end
  end

  assign usr_mode    = mode_d;
  assign usr_data_in = data_d;
  assign ser_valid   = ser_valid_q;
  assign ser_last    = ser_last_q;
  assign ser_sel     = ser_sel_q;
endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Directed bench: sequencer driving a modelled universal shift register, exit bits scoreboarded.
module tb_usr_shift_sequencer;
  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_dir;
  logic         stall;
  logic [1:0]   usr_mode;
  logic [W-1:0] usr_data_in;
  logic         ser_valid;
  logic         ser_last;
  logic         ser_sel;
  logic [2:0]   fifo_count;

  logic [W-1:0] reg_q;

  typedef struct {
    logic bit_v;
    logic last;
    logic sel;
  } exp_t;

  exp_t sb_q[$];
  int   checks_total  = 0;
  int   checks_passed = 0;

  always #5 clock = ~clock;

  usr_shift_sequencer #(.WIDTH(W), .FIFO_DEPTH(4), .FILL(1'b0)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_dir      (in_dir),
    .stall       (stall),
    .usr_mode    (usr_mode),
    .usr_data_in (usr_data_in),
    .ser_valid   (ser_valid),
    .ser_last    (ser_last),
    .ser_sel     (ser_sel),
    .fifo_count  (fifo_count)
  );

  // Behavioural universal shift register: 00 hold, 01 shift right, 10 shift left, 11 load.
  always @(posedge clock) begin
    if (reset) reg_q <= '0;
    else begin
      case (usr_mode)
        2'b01:   reg_q <= {usr_data_in[0], reg_q[W-1:1]};
        2'b10:   reg_q <= {reg_q[W-2:0], usr_data_in[0]};
        2'b11:   reg_q <= usr_data_in;
        default: reg_q <= reg_q;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sb_push(input logic [W-1:0] d, input logic dir);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.bit_v = dir ? d[W-1-i] : d[i];
      e.last  = (i == W-1);
      e.sel   = dir;
      sb_q.push_back(e);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d, input logic dir);
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    check("push_ready", in_ready, 1);
    sb_push(d, dir);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_seq(input string tag, input int n, input logic [31:0] modes,
                         input logic [15:0] valids, input logic [15:0] lasts);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_mode%0d", tag, i), usr_mode, modes[2*i +: 2]);
      check($sformatf("%s_valid%0d", tag, i), ser_valid, valids[i]);
      check($sformatf("%s_last%0d", tag, i), ser_last, lasts[i]);
      tick();
    end
  endtask

  // Scoreboard: every fresh exit bit must match the next expected bit in order.
  always @(negedge clock) begin
    if (ser_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_valid", ser_valid, 0);
      end else begin
        exp_t e;
        logic exit_bit;
        e = sb_q.pop_front();
        exit_bit = e.sel ? reg_q[W-1] : reg_q[0];
        check("sb_bit", exit_bit, e.bit_v);
        check("sb_last", ser_last, e.last);
        check("sb_sel", ser_sel, e.sel);
        $display("bit out=%0b last=%0b sel=%0b (exp %0b/%0b/%0b)",
                 exit_bit, ser_last, ser_sel, e.bit_v, e.last, e.sel);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'hF;
    in_dir   = 1'b0;
    stall    = 1'b0;

    // 1. Reset held with in_valid asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_mode", usr_mode, 2'b00);
      check("rst_ser_valid", ser_valid, 0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_reg", reg_q, 0);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("idle_mode", usr_mode, 2'b00);
    check("idle_count", fifo_count, 0);

    // 2. LSB-first word
    push_word(4'b1011, 1'b0);
    run_seq("t2", 6, {20'd0, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b11},
            16'b011110, 16'b010000);
    $display("t2 done: 4'b1011 dir=0");

    // 3. MSB-first word
    push_word(4'b1011, 1'b1);
    run_seq("t3", 6, {20'd0, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b11},
            16'b011110, 16'b010000);
    $display("t3 done: 4'b1011 dir=1");

    // 4. Back-to-back words: second LOAD lands in the cnt==3 slot
    in_valid = 1'b1;
    in_data  = 4'hA;
    in_dir   = 1'b0;
    check("t4_ready_a", in_ready, 1);
    sb_push(4'hA, 1'b0);
    tick();
    in_data = 4'h5;
    check("t4_ready_b", in_ready, 1);
    sb_push(4'h5, 1'b0);
    check("t4_mode0", usr_mode, 2'b11);
    check("t4_valid0", ser_valid, 0);
    tick();
    in_valid = 1'b0;
    run_seq("t4", 9, {14'd0, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b01},
            16'b011111111, 16'b010001000);
    $display("t4 done: 4'hA,4'h5 back-to-back");

    // 5. Fill while stalled, then stall mid-word
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [W-1:0] w;
      w        = W'(3 * (i + 1));
      in_valid = 1'b1;
      in_data  = w;
      in_dir   = 1'b0;
      check($sformatf("t5_ready%0d", i), in_ready, (i < 4) ? 1 : 0);
      if (i < 4) sb_push(w, 1'b0);
      tick();
      check($sformatf("t5_stall_mode%0d", i), usr_mode, 2'b00);
    end
    in_valid = 1'b0;
    check("t5_count_full", fifo_count, 4);
    check("t5_ready_full", in_ready, 0);
    check("t5_no_valid", ser_valid, 0);
    stall = 1'b0;
    #1;
    check("t5_load", usr_mode, 2'b11);
    tick();
    check("t5_bit1", ser_valid, 1);
    tick();
    check("t5_bit2", ser_valid, 1);
    stall = 1'b1;
    #1;
    check("t5_hold", usr_mode, 2'b00);
    tick();
    check("t5_gap1", ser_valid, 0);
    tick();
    check("t5_gap2", ser_valid, 0);
    stall = 1'b0;
    #1;
    check("t5_resume", usr_mode, 2'b01);
    for (int k = 0; k < 40 && sb_q.size() != 0; k++) tick();
    check("t5_drained", sb_q.size(), 0);
    tick();
    tick();
    check("t5_count_empty", fifo_count, 0);
    check("t5_idle_mode", usr_mode, 2'b00);
    $display("t5 done: stall and full FIFO");

    // 6. Reset in the middle of a word
    push_word(4'hC, 1'b0);
    check("t6_load", usr_mode, 2'b11);
    tick();
    check("t6_bit1", ser_valid, 1);
    tick();
    check("t6_bit2", ser_valid, 1);
    reset = 1'b1;
    tick();
    check("t6_mode", usr_mode, 2'b00);
    check("t6_count", fifo_count, 0);
    check("t6_valid", ser_valid, 0);
    check("t6_ready", in_ready, 0);
    sb_q.delete();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("t6_quiet%0d", k), ser_valid, 0);
      check($sformatf("t6_quiet_mode%0d", k), usr_mode, 2'b00);
    end
    check("t6_reg", reg_q, 0);
    $display("t6 done: reset mid-word");

    check("final_sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
